uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//   Receive sequencer for the XBee serial link on the Nexys2 board. Samples the rx line at
//   16x baud, qualifies start bits, and emits one mid-bit strobe plus a voted bit per data bit
//   to the shift-register deserializer. Closes each frame with frame_done or frame_err.
//   Sits between the rx pin and the deserializer; owns all timing, and the deserializer owns data.
// PARAMETERS
//   CLK_HZ     50_000_000  system clock frequency (Nexys2 oscillator)
//   BAUD       9600        line rate
//   OVERSAMPLE 16          samples per bit period; must be even and >= 8
//   DATA_BITS  8           data bits per frame (LSB first, no parity, 1 stop)
// PORTS
//   clk          in   1  system clock, all logic on rising edge
//   rst_n        in   1  asynchronous active-low reset
//   rx           in   1  raw serial line, asynchronous, idle high
//   bit_tick     out  1  1-cycle pulse at the mid-point of each data bit (deserializer shift strobe)
//   bit_val      out  1  majority-voted bit value, valid while bit_tick=1
//   shift_en     out  1  high from the first data-bit strobe until the frame ends (deserializer enable)
//   frame_done   out  1  1-cycle pulse when a valid stop bit is seen; deserializer latches its data
//   frame_err    out  1  1-cycle pulse when the stop bit samples 0 (framing error or break)
//   busy         out  1  high in every state except IDLE
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, counters 0, synchronizer flops reset to 1 (idle line).
//   rx passes through a 2-flop synchronizer; rx_s is the 2nd flop. Latency from rx to rx_s is 2 clk.
//   os_tick: a 1-cycle pulse every DIV clocks. DIV = (CLK_HZ + BAUD*OVERSAMPLE/2)/(BAUD*OVERSAMPLE),
//     which gives 326 at the defaults. os_cnt counts os_tick within a bit, 0..OVERSAMPLE-1, and wraps.
//   Voting: samples are taken at os_cnt = OS/2-1, OS/2, OS/2+1. The value is the majority of the 3 and
//     is decided on the os_tick where os_cnt = OS/2+1.
//   FSM:
//     IDLE   : when rx_s==0, clear the divider and os_cnt and go to START. busy rises on the next clk.
//     START  : when the vote is decided, a result of 1 means a false start: go to IDLE with no outputs.
//              A result of 0 sets bit_idx=0 and goes to DATA at the wrap of os_cnt.
//     DATA   : at each decide point, pulse bit_tick for 1 clk with bit_val=vote. shift_en goes to 1 on
//              the first strobe. bit_idx increments at each os_cnt wrap.
//              After the wrap that follows bit DATA_BITS-1, go to STOP.
//     STOP   : at the decide point, a vote of 1 pulses frame_done and goes to IDLE. A vote of 0 pulses
//              frame_err and goes to BRK. shift_en clears in the same cycle as either pulse.
//     BRK    : stay until rx_s has been 1 for OVERSAMPLE consecutive os_ticks, then go to IDLE.
//   Exactly DATA_BITS bit_ticks occur per accepted frame. frame_done and frame_err are mutually exclusive.
//   Back-to-back frames: a falling edge immediately after the stop-bit decide point is accepted.
//     IDLE is re-entered before the stop bit ends, so no start bit is lost.
//   A glitch shorter than OS/2-1 os_ticks is rejected in START.
//   rx activity in BRK is ignored.
//   Reset mid-frame: outputs clear asynchronously and no partial-frame pulse is issued.
//   Counter widths: $clog2(DIV), $clog2(OVERSAMPLE), $clog2(DATA_BITS+1). DIV < 2 is a parameter error
//     and is rejected at elaboration.
// STRUCTURE
//   uart_pkg:
//     - state enum (IDLE, START, DATA, STOP, BRK)
//     - function calc_div(clk_hz, baud, os)
//     - constant for the vote window offsets
//   Sub-module uart_baud_gen (clk, rst_n, clr, os_tick): the DIV counter. It is reused by the transmit path.
//   The FSM, voter and synchronizer stay in uart_rx_ctrl.
// TESTING (bench parameters CLK_HZ=1_600_000, BAUD=10_000, so DIV=10 and one bit = 160 clk)
//   1. Frame 0x55 -> 8 bit_ticks with bit_val 1,0,1,0,1,0,1,0, spaced 160 clk apart, then 1 frame_done.
//      No frame_err.
//   2. rx low for 3 os_ticks (30 clk), then high -> busy pulses, then back to IDLE.
//      0 bit_ticks, no frame_done, no frame_err.
//   3. Frame 0xA3 with stop bit forced 0, then line held low for 20 bits -> 8 bit_ticks and 1 frame_err.
//      busy stays 1 until 16 os_ticks after rx returns high.
//   4. Back-to-back 0xA3 then 0x3C with zero idle gap -> 16 bit_ticks total and 2 frame_done pulses.
//      Voted bits match both bytes LSB first.
//   5. Single-sample glitch (1 clk low) at os_cnt=OS/2 inside a data bit of 0xFF -> all bit_val=1,
//      frame_done is asserted.
//   6. rst_n low during bit 4 of a frame, released after 5 clk -> all outputs 0 at once.
//      The next clean frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, divider calculation and vote window.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } rx_state_t;

    // Samples are taken at mid-bit minus/plus this many oversample ticks.
    localparam int VOTE_OFFSET = 1;

    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle os_tick every DIV clocks, restartable with clr.
`timescale 1ns/1ps
module uart_baud_gen #(
    parameter int DIV = 326
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic os_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    if (DIV < 2) begin : g_bad_div
        $error("uart_baud_gen: DIV must be at least 2");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign os_tick = (cnt == CNT_LAST) && !clr;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive sequencer: synchronizes rx, qualifies start bits, votes each bit at mid-point
// and strobes the deserializer; closes every frame with frame_done or frame_err.
`timescale 1ns/1ps
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic bit_tick,
    output logic bit_val,
    output logic shift_en,
    output logic frame_done,
    output logic frame_err,
    output logic busy
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  OS_EARLY = OS_W'(OVERSAMPLE / 2 - VOTE_OFFSET);
    localparam logic [OS_W-1:0]  OS_LATE  = OS_W'(OVERSAMPLE / 2 + VOTE_OFFSET);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx_ctrl: OVERSAMPLE must be even and >= 8");
    end

    rx_state_t        state;
    rx_state_t        state_next;
    logic             rx_meta;
    logic             rx_s;
    logic             os_tick;
    logic             clr;
    logic [OS_W-1:0]  os_cnt;
    logic [OS_W-1:0]  hi_cnt;
    logic [IDX_W-1:0] bit_idx;
    logic             samp_early;
    logic             samp_mid;
    logic             shift_q;
    logic             start_ok;
    logic             decide;
    logic             wrap;
    logic             vote;

    uart_baud_gen #(.DIV(DIV)) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .os_tick (os_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign decide = os_tick && (os_cnt == OS_LATE);
    assign wrap   = os_tick && (os_cnt == OS_LAST);
    // The third vote sample is the live synchronized line at the decide tick.
    assign vote   = (samp_early & samp_mid) | (samp_early & rx_s) | (samp_mid & rx_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_cnt     <= '0;
            hi_cnt     <= '0;
            bit_idx    <= '0;
            samp_early <= 1'b1;
            samp_mid   <= 1'b1;
            shift_q    <= 1'b0;
        end else begin
            if (clr) begin
                os_cnt <= '0;
            end else if (os_tick) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
            end

            if (os_tick && os_cnt == OS_EARLY) begin
                samp_early <= rx_s;
            end
            if (os_tick && os_cnt == OS_MID) begin
                samp_mid <= rx_s;
            end

            if (start_ok) begin
                bit_idx <= '0;
            end else if (state == DATA && wrap) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end

            // Counts consecutive high ticks while waiting for a break to end.
            if (state != BRK) begin
                hi_cnt <= '0;
            end else if (os_tick) begin
                hi_cnt <= rx_s ? hi_cnt + OS_W'(1) : '0;
            end

            if (frame_done || frame_err) begin
                shift_q <= 1'b0;
            end else if (bit_tick) begin
                shift_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        clr        = 1'b0;
        start_ok   = 1'b0;
        bit_tick   = 1'b0;
        bit_val    = 1'b0;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    clr        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (decide) begin
                    if (vote) begin
                        state_next = IDLE;
                    end else begin
                        start_ok = 1'b1;
                    end
                end else if (wrap) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (decide) begin
                    bit_tick = 1'b1;
                    bit_val  = vote;
                end else if (wrap && bit_idx == IDX_LAST) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    if (vote) begin
                        frame_done = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err  = 1'b1;
                        state_next = BRK;
                    end
                end
            end
            BRK: begin
                if (os_tick && rx_s && hi_cnt == OS_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign shift_en = (shift_q | bit_tick) & ~(frame_done | frame_err);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: stimulus pushes expected bits and frame events,
// a negedge monitor pops and compares whenever the DUT strobes.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int CLK_HZ    = 1_600_000;
    localparam int BAUD      = 10_000;
    localparam int OS        = 16;
    localparam int DATA_BITS = 8;
    localparam int BIT_CLK   = 160;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic bit_tick, bit_val, shift_en, frame_done, frame_err, busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_tick      = 0;
    int ticks_in_frame = 0;

    logic       exp_bits[$];
    logic [1:0] exp_evt[$];

    uart_rx_ctrl #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS),
        .DATA_BITS  (DATA_BITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .bit_tick   (bit_tick),
        .bit_val    (bit_val),
        .shift_en   (shift_en),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drives one full frame from a negedge; glitch_bit flips that data bit for one clock at offset 90.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int glitch_bit);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < DATA_BITS; i++) begin
            exp_bits.push_back(data[i]);
            rx = data[i];
            if (i == glitch_bit) begin
                repeat (90) @(negedge clk);
                rx = ~data[i];
                @(negedge clk);
                rx = data[i];
                repeat (BIT_CLK - 91) @(negedge clk);
            end else begin
                repeat (BIT_CLK) @(negedge clk);
            end
        end
        exp_evt.push_back(stop_bit ? 2'b01 : 2'b10);
        rx = stop_bit;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic idleBits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CLK) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            ticks_in_frame = 0;
        end else begin
            if (bit_tick) begin
                checkOutput("bit_tick_expected", 32'(exp_bits.size() > 0), 1);
                if (exp_bits.size() > 0) checkOutput("bit_val", 32'(bit_val), 32'(exp_bits.pop_front()));
                checkOutput("shift_en_at_tick", 32'(shift_en), 1);
                if (ticks_in_frame > 0) checkOutput("tick_spacing", cyc - last_tick, BIT_CLK);
                last_tick = cyc;
                ticks_in_frame++;
            end
            if (frame_done || frame_err) begin
                checkOutput("frame_event_expected", 32'(exp_evt.size() > 0), 1);
                if (exp_evt.size() > 0) checkOutput("frame_event", 32'({frame_err, frame_done}), 32'(exp_evt.pop_front()));
                checkOutput("ticks_per_frame", ticks_in_frame, DATA_BITS);
                checkOutput("shift_en_cleared", 32'(shift_en), 0);
                ticks_in_frame = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] part;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_bit_tick", 32'(bit_tick), 0);
        checkOutput("reset_shift_en", 32'(shift_en), 0);
        checkOutput("reset_frame_done", 32'(frame_done), 0);
        checkOutput("reset_frame_err", 32'(frame_err), 0);
        rst_n = 1'b1;
        idleBits(1);

        $display("[TB] test 1: frame 0x55");
        applyStimulus(8'h55, 1'b1, -1);
        idleBits(2);

        $display("[TB] test 2: false start");
        rx = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("false_start_busy_high", 32'(busy), 1);
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (170) @(negedge clk);
        checkOutput("false_start_busy_low", 32'(busy), 0);
        idleBits(1);

        $display("[TB] test 3: framing error and break");
        applyStimulus(8'hA3, 1'b0, -1);
        rx = 1'b0;
        repeat (20 * BIT_CLK) @(negedge clk);
        checkOutput("break_busy_during_low", 32'(busy), 1);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("break_busy_before_16", 32'(busy), 1);
        repeat (100) @(negedge clk);
        checkOutput("break_busy_after_16", 32'(busy), 0);
        idleBits(1);

        $display("[TB] test 4: back-to-back frames");
        applyStimulus(8'hA3, 1'b1, -1);
        applyStimulus(8'h3C, 1'b1, -1);
        idleBits(2);

        $display("[TB] test 5: glitch inside data bit");
        applyStimulus(8'hFF, 1'b1, 3);
        idleBits(2);

        $display("[TB] test 6: reset mid-frame");
        part = 8'hC6;
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            exp_bits.push_back(part[i]);
            rx = part[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx = part[4];
        repeat (40) @(negedge clk);
        checkOutput("pre_reset_busy", 32'(busy), 1);
        checkOutput("pre_reset_shift_en", 32'(shift_en), 1);
        rst_n = 1'b0;
        rx = 1'b1;
        #1;
        checkOutput("async_reset_busy", 32'(busy), 0);
        checkOutput("async_reset_shift_en", 32'(shift_en), 0);
        checkOutput("async_reset_bit_tick", 32'(bit_tick), 0);
        checkOutput("async_reset_frame_done", 32'(frame_done), 0);
        checkOutput("async_reset_frame_err", 32'(frame_err), 0);
        @(negedge clk);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idleBits(2);
        applyStimulus(8'h81, 1'b1, -1);
        idleBits(2);

        checkOutput("bits_outstanding", exp_bits.size(), 0);
        checkOutput("events_outstanding", exp_evt.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
